generation_controller: RTL and testbench

GENERATION_CONTROLLER -- requirements
Module: generation_controller

---
 rtl/generation_controller.sv | 262 ++++++++++++++++++++++++++
 tb/tb_generation_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generation_controller.sv
`default_nettype none
// ============================================================================
// Module   : generation_controller
// Purpose  : Sequences one cellular-automaton generation over a double-banked
//            frame buffer. Rows are streamed from the source bank into a
//            three-row window (top/middle/bottom) that feeds an external
//            combinational next-state engine. The engine's result is written
//            to the matching row of the destination bank. When the frame is
//            finished the banks swap roles and the generation counter
//            advances.
// Build    : define TORUS_EN to wrap the frame vertically (row -1 is the last
//            row and row NUM_ROWS is row 0). Without it both vertical
//            boundaries are all-zero rows.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            start      - request one generation (sampled in IDLE only)
//            busy       - generation in progress
//            done       - one-cycle completion pulse
//            rd_en      - frame-buffer read strobe (data returns next cycle)
//            rd_addr    - {source bank, row}
//            rd_data    - row returned by the frame buffer
//            wr_en      - frame-buffer write strobe
//            wr_addr    - {destination bank, row}
//            wr_data    - next-state row (engine result while writing)
//            top_row    - window row r-1 to the engine
//            middle_row - window row r   to the engine
//            bottom_row - window row r+1 to the engine
//            result     - engine next-state row for the middle row
//            gen_count  - completed generations, modulo 2**16
// Revision : 1.0 - initial release
// ============================================================================
module generation_controller #(
  parameter int ROW_LENGTH = 1280,
  parameter int NUM_ROWS   = 720,
  parameter int ROW_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ROW_AW:0]       rd_addr,
  input  logic [ROW_LENGTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ROW_AW:0]       wr_addr,
  output logic [ROW_LENGTH-1:0] wr_data,
  output logic [ROW_LENGTH-1:0] top_row,
  output logic [ROW_LENGTH-1:0] middle_row,
  output logic [ROW_LENGTH-1:0] bottom_row,
  input  logic [ROW_LENGTH-1:0] result,
  output logic [15:0]           gen_count
);

  // Reads are numbered by a sequence index. In the zero-boundary build the
  // sequence index equals the row. In the torus build one extra leading read
  // of the last row supplies row -1, so every row sits one sequence step
  // later and the window needs one more shift before the first write.
`ifdef TORUS_EN
  localparam int c_lag = 2;
`else
  localparam int c_lag = 1;
`endif

  // First sequence index whose arrival completes a writable window.
  localparam logic [ROW_AW:0]   c_lag_seq  = (ROW_AW+1)'(c_lag);
  // Sequence index of the last real read (row NUM_ROWS-1).
  localparam logic [ROW_AW:0]   c_last_seq = (ROW_AW+1)'(NUM_ROWS + c_lag - 2);
  localparam logic [ROW_AW-1:0] c_last_row = ROW_AW'(NUM_ROWS - 1);
  localparam logic [ROW_AW:0]   c_seq_one  = (ROW_AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_src_bank;
  logic [15:0]           r_gen_count;

  // Read issue side.
  logic                  r_rd_en;
  logic [ROW_AW:0]       r_rd_seq;
  logic [ROW_AW:0]       r_rd_addr;

  // Read return side: r_ld marks a cycle in which rd_data is valid,
  // r_ld_seq is the sequence index of that data, r_ld_virt marks the cycle
  // in which the virtual row after the last row is shifted in.
  logic                  r_ld;
  logic [ROW_AW:0]       r_ld_seq;
  logic                  r_ld_virt;

  // Write side.
  logic                  r_wr_en;
  logic [ROW_AW:0]       r_wr_addr;

  // Window.
  logic [ROW_LENGTH-1:0] r_top;
  logic [ROW_LENGTH-1:0] r_mid;
  logic [ROW_LENGTH-1:0] r_bot;

  // Row shifted in after the last real row.
  logic [ROW_LENGTH-1:0] w_virt_row;

`ifdef TORUS_EN
  // Row 0 is captured on its way through the window so it can be replayed as
  // row NUM_ROWS without a second read.
  logic [ROW_LENGTH-1:0] r_row0;
  assign w_virt_row = r_row0;
`else
  assign w_virt_row = '0;
`endif

  // Row index addressed by a given read sequence index.
  function automatic logic [ROW_AW-1:0] seq_to_rd_row(input logic [ROW_AW:0] seq);
    logic [ROW_AW:0] v;
`ifdef TORUS_EN
    v = (seq == '0) ? {1'b0, c_last_row} : (seq - c_seq_one);
`else
    v = seq;
`endif
    return v[ROW_AW-1:0];
  endfunction

  // Row written once the data of sequence index seq reaches bottom_row.
  function automatic logic [ROW_AW-1:0] seq_to_wr_row(input logic [ROW_AW:0] seq);
    logic [ROW_AW:0] v;
    v = seq - c_lag_seq;
    return v[ROW_AW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_src_bank  <= 1'b0;
      r_gen_count <= '0;
      r_rd_en     <= 1'b0;
      r_rd_seq    <= '0;
      r_rd_addr   <= '0;
      r_ld        <= 1'b0;
      r_ld_seq    <= '0;
      r_ld_virt   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_top       <= '0;
      r_mid       <= '0;
      r_bot       <= '0;
`ifdef TORUS_EN
      r_row0      <= '0;
`endif
    end else begin
      r_done    <= 1'b0;

      // Read-return pipeline tracks the one-cycle frame-buffer latency.
      r_ld      <= r_rd_en;
      r_ld_seq  <= r_rd_seq;
      r_ld_virt <= r_ld && (r_ld_seq == c_last_seq);

      // Window advance: real data when a read returns, otherwise the
      // virtual boundary row right after the last real row.
      if (r_ld) begin
        r_top <= r_mid;
        r_mid <= r_bot;
        r_bot <= rd_data;
      end else if (r_ld_virt) begin
        r_top <= r_mid;
        r_mid <= r_bot;
        r_bot <= w_virt_row;
      end

`ifdef TORUS_EN
      if (r_ld && (r_ld_seq == (c_lag_seq - c_seq_one))) begin
        r_row0 <= rd_data;
      end
`endif

      // One read per cycle until the last sequence index has been issued.
      if (r_rd_en) begin
        if (r_rd_seq == c_last_seq) begin
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
        end else begin
          r_rd_seq  <= r_rd_seq + c_seq_one;
          r_rd_addr <= {r_src_bank, seq_to_rd_row(r_rd_seq + c_seq_one)};
        end
      end

      // A write follows every shift that completes a window (r-1, r, r+1).
      // The bank is sampled here, before it toggles at the end of the run.
      if (r_ld && (r_ld_seq >= c_lag_seq)) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {~r_src_bank, seq_to_wr_row(r_ld_seq)};
      end else if (r_ld_virt) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= {~r_src_bank, c_last_row};
      end else begin
        r_wr_en   <= 1'b0;
        r_wr_addr <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_PRIME;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_seq  <= '0;
            r_rd_addr <= {r_src_bank, seq_to_rd_row('0)};
            // Clearing the whole window makes top_row the zero row -1 once
            // the first two real rows have been shifted in.
            r_top     <= '0;
            r_mid     <= '0;
            r_bot     <= '0;
          end
        end
        S_PRIME: begin
          if (r_ld && (r_ld_seq == c_lag_seq)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_wr_en && (r_wr_addr[ROW_AW-1:0] == c_last_row)) begin
            r_state     <= S_FINISH;
            r_done      <= 1'b1;
            r_src_bank  <= ~r_src_bank;
            r_gen_count <= r_gen_count + 16'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  // The engine is combinational on the window, so its result is valid in
  // the same cycle as the write strobe; it is gated to zero otherwise.
  assign wr_data    = r_wr_en ? result : '0;
  assign top_row    = r_top;
  assign middle_row = r_mid;
  assign bottom_row = r_bot;
  assign gen_count  = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_generation_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_generation_controller
// Purpose  : Self-checking bench for generation_controller with an 8x5 frame.
//            Provides a two-bank frame buffer, a Conway-life next-state
//            engine and a frame-level reference model of one generation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generation_controller;

  localparam int N  = 5;
  localparam int L  = 8;
  localparam int AW = 3;
`ifdef TORUS_EN
  localparam int c_lag   = 2;
  localparam bit c_torus = 1'b1;
`else
  localparam int c_lag   = 1;
  localparam bit c_torus = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW:0]   rd_addr;
  logic [L-1:0]  rd_data;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [L-1:0]  wr_data;
  logic [L-1:0]  top_row;
  logic [L-1:0]  middle_row;
  logic [L-1:0]  bottom_row;
  logic [L-1:0]  result;
  logic [15:0]   gen_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_src = 0;
  int m_gen = 0;
  int tot_wr = 0;

  // Frame buffer: index = bank*8 + row.
  logic [L-1:0]  mem [0:15];
  logic          tb_we;
  logic [3:0]    tb_waddr;
  logic [L-1:0]  tb_wdata;

  generation_controller #(
    .ROW_LENGTH (L),
    .NUM_ROWS   (N),
    .ROW_AW     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .top_row    (top_row),
    .middle_row (middle_row),
    .bottom_row (bottom_row),
    .result     (result),
    .gen_count  (gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  // Conway life on one row, horizontal edges are dead cells.
  function automatic logic [L-1:0] life_row(input logic [L-1:0] t, input logic [L-1:0] m,
                                            input logic [L-1:0] b);
    logic [L-1:0] o;
    int n;
    o = '0;
    for (int c = 0; c < L; c++) begin
      n = 0;
      for (int d = -1; d <= 1; d++) begin
        if ((c + d >= 0) && (c + d < L)) begin
          n += int'(t[c+d]) + int'(b[c+d]);
          if (d != 0) n += int'(m[c+d]);
        end
      end
      o[c] = (n == 3) || (m[c] && (n == 2));
    end
    return o;
  endfunction

  always_comb begin
    result = life_row(top_row, middle_row, bottom_row);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int addr, input logic [L-1:0] data);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = 4'(addr);
    tb_wdata = data;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy,       0);
    chk({tag, "_done"},      done,       0);
    chk({tag, "_rd_en"},     rd_en,      0);
    chk({tag, "_wr_en"},     wr_en,      0);
    chk({tag, "_rd_addr"},   rd_addr,    0);
    chk({tag, "_wr_addr"},   wr_addr,    0);
    chk({tag, "_wr_data"},   wr_data,    0);
    chk({tag, "_top"},       top_row,    0);
    chk({tag, "_mid"},       middle_row, 0);
    chk({tag, "_bot"},       bottom_row, 0);
    chk({tag, "_gen_count"}, gen_count,  0);
  endtask

  // One generation: build the expected next frame from the current source
  // bank, start the DUT and check every read, write and the done pulse.
  task automatic run_gen(input bit hold_start, input string tag);
    logic [L-1:0] src_f [N];
    logic [L-1:0] exp_f [N];
    logic [L-1:0] t, b;
    int wr_cnt, rd_cnt, done_cnt, done_cyc, exp_done, first_wr, n_reads, exp_row;
    for (int r = 0; r < N; r++) src_f[r] = mem[m_src*8 + r];
    for (int r = 0; r < N; r++) begin
      if (r == 0)     t = c_torus ? src_f[N-1] : '0;
      else            t = src_f[r-1];
      if (r == N - 1) b = c_torus ? src_f[0] : '0;
      else            b = src_f[r+1];
      exp_f[r] = life_row(t, src_f[r], b);
    end
    n_reads  = N + c_lag - 1;
    first_wr = 3 + c_lag;
    exp_done = N + 3 + c_lag;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1;

    @(negedge clk);
    chk({tag, "_idle_before"}, busy, 0);
    start = 1'b1;
    @(posedge clk);                       // end of cycle 0: start accepted
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold_start || ((done_cyc >= 0) && (k == done_cyc + 1))) start = 1'b0;
      if (k == 1) chk({tag, "_busy_c1"}, busy, 1);
      if (rd_en) begin
        exp_row = (c_torus && (rd_cnt == 0)) ? N - 1 : rd_cnt - (c_lag - 1);
        chk({tag, "_rd_bank"}, rd_addr[AW], m_src);
        chk({tag, "_rd_row"}, rd_addr[AW-1:0], exp_row);
        rd_cnt++;
      end
      if (wr_en) begin
        chk({tag, "_wr_bank"}, wr_addr[AW], 1 - m_src);
        chk({tag, "_wr_row"}, wr_addr[AW-1:0], wr_cnt);
        chk({tag, "_wr_cycle"}, k, first_wr + wr_cnt);
        if (wr_cnt < N) chk({tag, "_wr_data"}, wr_data, exp_f[wr_cnt]);
        wr_cnt++;
        tot_wr++;
      end
      if (done) begin
        chk({tag, "_done_cycle"}, k, exp_done);
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if ((done_cyc >= 0) && (k == done_cyc + 1)) chk({tag, "_idle_after_done"}, busy, 0);
      if ((done_cyc >= 0) && (k == done_cyc + 2)) begin
        chk({tag, "_no_restart"}, busy, 0);
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_rd_count"}, rd_cnt, n_reads);
    chk({tag, "_wr_count"}, wr_cnt, N);
    chk({tag, "_done_count"}, done_cnt, 1);
    m_src = 1 - m_src;
    m_gen = (m_gen + 1) % 65536;
    chk({tag, "_gen_count"}, gen_count, m_gen);
    for (int r = 0; r < N; r++) chk({tag, "_frame"}, mem[m_src*8 + r], exp_f[r]);
  endtask

  task automatic reset_mid_run();
    int found, stray;
    found = 0;
    stray = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en && (wr_addr[AW-1:0] == 3'd2)) begin
        found = 1;
        break;
      end
    end
    chk("mid_rst_found_row2", found, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (wr_en || busy) stray++;
    end
    chk("mid_rst_quiet", stray, 0);
    m_src = 0;
    m_gen = 0;
  endtask

  initial begin
    int wr_base;
    rst_n = 1'b0;
    start = 1'b0;
    tb_we = 1'b0;
    tb_waddr = '0;
    tb_wdata = '0;
    rd_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("por_stays_idle", busy, 0);

    // Vertical blinker in column 3, rows 1-3; destination bank holds noise.
    for (int r = 0; r < N; r++) poke(r, ((r >= 1) && (r <= 3)) ? 8'h08 : 8'h00);
    for (int r = 0; r < N; r++) poke(8 + r, 8'($urandom));
    run_gen(1'b0, "g1");
    chk("g1_row0", mem[8], 8'h00);
    chk("g1_row1", mem[9], 8'h00);
    chk("g1_row2", mem[10], 8'h1C);
    chk("g1_row3", mem[11], 8'h00);
    chk("g1_row4", mem[12], 8'h00);
    chk("g1_gen", gen_count, 1);

    run_gen(1'b0, "g2");
    chk("g2_row1", mem[1], 8'h08);
    chk("g2_row2", mem[2], 8'h08);
    chk("g2_row3", mem[3], 8'h08);
    chk("g2_gen", gen_count, 2);

    // start held high for the whole run, including the done cycle.
    for (int r = 0; r < N; r++) poke(m_src*8 + r, 8'($urandom));
    run_gen(1'b1, "hold");

    repeat (3) begin
      for (int r = 0; r < N; r++) poke(m_src*8 + r, 8'($urandom));
      run_gen($urandom_range(0, 1) == 1, "rnd");
    end

    reset_mid_run();
    run_gen(1'b0, "post_rst");

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst2");
    rst_n = 1'b1;
    m_src = 0;
    m_gen = 0;
    for (int r = 0; r < N; r++) poke(r, 8'h00);
    for (int r = 0; r < N; r++) poke(8 + r, 8'h00);
    wr_base = tot_wr;
    repeat (3) run_gen(1'b0, "zero");
    chk("zero_total_writes", tot_wr - wr_base, 3 * N);
    chk("zero_gen_count", gen_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
